msrv32_store_unit: RTL

- Write-side counterpart of the load path in the msrv32 RV32I core.
- Takes a store request from the execute stage (SB/SH/SW, effective address, rs2 value) and issues it to data memory over the AHB-Lite-style two-phase interface. The address phase is followed by the data phase.
- Performs byte-lane replication, write-mask generation and misalignment detection.
- Holds the transaction across wait states and reports completion, bus error or misalignment to the pipeline.

---
 rtl/msrv32_pkg.sv | 19 +
 rtl/msrv32_store_lane_gen.sv | 37 +++
 rtl/msrv32_store_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 store path.
// Store sizes, AHB transfer types and the store FSM encoding.
package msrv32_pkg;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ADDR  = 2'b01,
        S_DATA  = 2'b10,
        S_MISAL = 2'b11
    } st_state_e;

endpackage

// File: rtl/msrv32_store_lane_gen.sv
// Store lane generator: replicates rs2 across byte lanes,
// builds the byte write mask and flags misaligned accesses.
module msrv32_store_lane_gen
    import msrv32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       i_funct3,
    input  logic [1:0]       i_addr_lo,
    input  logic [WIDTH-1:0] i_rs2,
    output logic [WIDTH-1:0] o_data,
    output logic [3:0]       o_mask,
    output logic             o_misaligned
);

    always_comb begin
        o_data       = i_rs2;
        o_mask       = 4'b1111;
        o_misaligned = 1'b0;
        case (i_funct3)
            ST_SB: begin
                o_data = {4{i_rs2[7:0]}};
                o_mask = 4'b0001 << i_addr_lo;
            end
            ST_SH: begin
                o_data       = {2{i_rs2[15:0]}};
                o_mask       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                // 2'b11 is handled as a word store
                o_misaligned = |i_addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/msrv32_store_unit.sv
// msrv32 store unit: issues SB/SH/SW over a two-phase AHB-Lite
// write, holding across wait states and reporting done/err/misaligned.
module msrv32_store_unit
    import msrv32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic [1:0]       funct3_in,
    input  logic [WIDTH-1:0] iadder_in,
    input  logic [WIDTH-1:0] rs2_in,
    input  logic             mem_wr_req_in,
    input  logic             ahb_ready_in,
    input  logic             ahb_resp_in,
    output logic             st_accept_out,
    output logic [WIDTH-1:0] ms_riscv32_mp_dmaddr_out,
    output logic [WIDTH-1:0] ms_riscv32_mp_dmdata_out,
    output logic [3:0]       ms_riscv32_mp_dmwr_mask_out,
    output logic             ms_riscv32_mp_dmwr_req_out,
    output logic [1:0]       ahb_htrans_out,
    output logic             st_done_out,
    output logic             st_err_out,
    output logic             misaligned_store_out
);

    logic [WIDTH-1:0] w_data;
    logic [3:0]       w_mask;
    logic             w_misaligned;

    st_state_e        r_state;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_dmaddr;
    logic [WIDTH-1:0] r_dmdata;
    logic [3:0]       r_mask;
    logic             r_dmwr_req;
    logic [1:0]       r_htrans;
    logic             r_done;
    logic             r_err;
    logic             r_misal;

    msrv32_store_lane_gen #(
        .WIDTH (WIDTH)
    ) u_lane_gen (
        .i_funct3     (funct3_in),
        .i_addr_lo    (iadder_in[1:0]),
        .i_rs2        (rs2_in),
        .o_data       (w_data),
        .o_mask       (w_mask),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state    <= S_IDLE;
            r_wdata    <= '0;
            r_dmaddr   <= '0;
            r_dmdata   <= '0;
            r_mask     <= '0;
            r_dmwr_req <= 1'b0;
            r_htrans   <= HTRANS_IDLE;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_misal    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_misal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_wr_req_in) begin
                        if (w_misaligned) begin
                            r_state <= S_MISAL;
                            r_misal <= 1'b1;
                            r_mask  <= '0;
                        end else begin
                            r_state    <= S_ADDR;
                            r_dmaddr   <= {iadder_in[WIDTH-1:2], 2'b00};
                            r_wdata    <= w_data;
                            r_mask     <= w_mask;
                            r_htrans   <= HTRANS_NONSEQ;
                            r_dmwr_req <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (ahb_ready_in) begin
                        r_state    <= S_DATA;
                        r_htrans   <= HTRANS_IDLE;
                        r_dmwr_req <= 1'b0;
                        r_dmdata   <= r_wdata;
                    end
                end
                S_DATA: begin
                    // HRESP only matters when the data phase completes
                    if (ahb_ready_in) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_err   <= ahb_resp_in;
                    end
                end
                S_MISAL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign st_accept_out               = (r_state == S_IDLE);
    assign ms_riscv32_mp_dmaddr_out    = r_dmaddr;
    assign ms_riscv32_mp_dmdata_out    = r_dmdata;
    assign ms_riscv32_mp_dmwr_mask_out = r_mask;
    assign ms_riscv32_mp_dmwr_req_out  = r_dmwr_req;
    assign ahb_htrans_out              = r_htrans;
    assign st_done_out                 = r_done;
    assign st_err_out                  = r_err;
    assign misaligned_store_out        = r_misal;

endmodule
